pc_generator: RTL

//  Parametrised program-counter generator for the RISC-V fetch stage; successor to the single-mux PC.

---
 rtl/pc_generator_pkg.sv | 23 ++
 rtl/pc_generator_next_sel.sv | 71 +++++++
 rtl/pc_generator.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pc_generator_pkg.sv
// ---------------------------------------------------------------------------
// pc_generator_pkg
//   Shared definitions for the fetch-stage program-counter generator:
//   FSM state encodings and the alignment mask used by fetch and decode to
//   decide whether a redirect target is legal.
// ---------------------------------------------------------------------------
package pc_generator_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } pc_state_e;

  // Low address bits that must be zero for a legal instruction address.
  localparam logic [1:0] ALIGN_MASK_WORD = 2'b11;  // 32-bit only ISA
  localparam logic [1:0] ALIGN_MASK_HALF = 2'b01;  // C extension present

  function automatic logic [1:0] align_mask(input bit c_ext);
    return c_ext ? ALIGN_MASK_HALF : ALIGN_MASK_WORD;
  endfunction

endpackage

// File: rtl/pc_generator_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
//   Purely combinational next-PC selection: priority mux, sequential step
//   adder and redirect-alignment check.
// Ports
//   i_state           current FSM state
//   i_fetch_addr      current registered fetch address
//   i_alu_pc          redirect target from the ALU
//   i_pc_mux          redirect request
//   i_trap_en         trap / interrupt request
//   i_advance         current fetch accepted and PC may step
//   i_inst_compressed current instruction is 16-bit (C_EXT builds only)
//   o_next_addr       fetch address to register at the next edge
//   o_seq_addr        fetch address + step (link value)
//   o_misalign_hit    redirect taken to the trap vector due to misalignment
// ---------------------------------------------------------------------------
module pc_next_sel
  import pc_generator_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(32'h0000_0100),
  parameter int              C_EXT       = 0
) (
  input  pc_state_e       i_state,
  input  logic [XLEN-1:0] i_fetch_addr,
  input  logic [XLEN-1:0] i_alu_pc,
  input  logic            i_pc_mux,
  input  logic            i_trap_en,
  input  logic            i_advance,
  input  logic            i_inst_compressed,
  output logic [XLEN-1:0] o_next_addr,
  output logic [XLEN-1:0] o_seq_addr,
  output logic            o_misalign_hit
);

  logic [XLEN-1:0] w_step;
  logic            w_misal;

  always_comb begin
    w_step = XLEN'(4);
    if ((C_EXT != 0) && i_inst_compressed) w_step = XLEN'(2);
  end

  // Wraps modulo 2^XLEN by construction.
  assign o_seq_addr = i_fetch_addr + w_step;
  assign w_misal    = |(i_alu_pc[1:0] & align_mask(C_EXT != 0));

  always_comb begin
    o_next_addr    = i_fetch_addr;
    o_misalign_hit = 1'b0;
    unique case (i_state)
      ST_RUN: begin
        // Redirects and traps win over stall / memory back-pressure.
        if (i_trap_en) begin
          o_next_addr = TRAP_VECTOR;
        end else if (i_pc_mux && !w_misal) begin
          o_next_addr = i_alu_pc;
        end else if (i_pc_mux) begin
          o_next_addr    = TRAP_VECTOR;
          o_misalign_hit = 1'b1;
        end else if (i_advance) begin
          o_next_addr = o_seq_addr;
        end
      end
      // Only an interrupt can move the PC out of halt; PCMux is ignored.
      ST_HALT: if (i_trap_en) o_next_addr = TRAP_VECTOR;
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_generator.sv
// ---------------------------------------------------------------------------
// pc_generator
//   Fetch-stage program counter with fetch handshake, boot delay,
//   halt/resume, trap vectoring, misaligned-redirect detection, optional
//   C-extension stepping and an accepted-fetch counter.
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   ALUPC           redirect target from the ALU
//   PCMux           take ALUPC
//   trap_en         take TRAP_VECTOR (also wakes from halt)
//   halt            level: stop issuing fetches
//   stall           level: hold PC for a pipeline hazard
//   inst_compressed current instruction is 16-bit (C_EXT=1 only)
//   imem_ready      instruction memory accepts fetch_addr this cycle
//   fetch_addr      registered fetch address
//   fetch_valid     registered fetch request qualifier
//   seq_addr        fetch_addr + step (combinational link value)
//   misaligned      one-cycle pulse on a misaligned redirect
//   bad_addr        ALUPC captured on the last misaligned redirect
//   fetch_count     number of accepted fetches
// ---------------------------------------------------------------------------
module pc_generator
  import pc_generator_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              C_EXT        = 0,
  parameter int              BOOT_DELAY   = 2,
  parameter int              CNT_W        = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  ALUPC,
  input  logic             PCMux,
  input  logic             trap_en,
  input  logic             halt,
  input  logic             stall,
  input  logic             inst_compressed,
  input  logic             imem_ready,
  output logic [XLEN-1:0]  fetch_addr,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  seq_addr,
  output logic             misaligned,
  output logic [XLEN-1:0]  bad_addr,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int              BCW       = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [BCW-1:0]  BOOT_LAST = BCW'(BOOT_DELAY - 1);

  pc_state_e        r_state;
  logic [BCW-1:0]   r_boot_cnt;
  logic [XLEN-1:0]  r_fetch_addr;
  logic             r_fetch_valid;
  logic             r_misaligned;
  logic [XLEN-1:0]  r_bad_addr;
  logic [CNT_W-1:0] r_fetch_count;

  logic             w_accept;
  logic             w_advance;
  logic [XLEN-1:0]  w_next_addr;
  logic [XLEN-1:0]  w_seq_addr;
  logic             w_misalign_hit;

  // A fetch is handed to memory whenever the request is valid and taken.
  assign w_accept  = r_fetch_valid && imem_ready && !stall;
  // A halting cycle still completes its handshake but the PC stays put so
  // the same address is re-issued on resume.
  assign w_advance = w_accept && !halt;

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .C_EXT       (C_EXT)
  ) u_next_sel (
    .i_state           (r_state),
    .i_fetch_addr      (r_fetch_addr),
    .i_alu_pc          (ALUPC),
    .i_pc_mux          (PCMux),
    .i_trap_en         (trap_en),
    .i_advance         (w_advance),
    .i_inst_compressed (inst_compressed),
    .o_next_addr       (w_next_addr),
    .o_seq_addr        (w_seq_addr),
    .o_misalign_hit    (w_misalign_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_BOOT;
      r_boot_cnt    <= '0;
      r_fetch_addr  <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_bad_addr    <= '0;
      r_fetch_count <= '0;
    end else begin
      r_fetch_addr <= w_next_addr;
      r_misaligned <= w_misalign_hit;
      if (w_misalign_hit) r_bad_addr <= ALUPC;
      if (w_accept) r_fetch_count <= r_fetch_count + CNT_W'(1);

      unique case (r_state)
        ST_BOOT: begin
          r_fetch_valid <= 1'b0;
          if (r_boot_cnt == BOOT_LAST) begin
            r_state       <= ST_RUN;
            r_fetch_valid <= !stall;
          end else begin
            r_boot_cnt <= r_boot_cnt + BCW'(1);
          end
        end
        ST_RUN: begin
          if (halt) begin
            r_state       <= ST_HALT;
            r_fetch_valid <= 1'b0;
          end else begin
            r_fetch_valid <= !stall;
          end
        end
        ST_HALT: begin
          if (trap_en || !halt) begin
            r_state       <= ST_RUN;
            r_fetch_valid <= !stall;
          end else begin
            r_fetch_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_BOOT;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_addr  = r_fetch_addr;
  assign fetch_valid = r_fetch_valid;
  assign seq_addr    = w_seq_addr;
  assign misaligned  = r_misaligned;
  assign bad_addr    = r_bad_addr;
  assign fetch_count = r_fetch_count;

endmodule
